fpu_addsub_frontend: RTL and testbench

Operand front-end for the single-precision add/subtract unit. It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. It classifies each pair and resolves the IEEE-754 special cases that the combinational adder does not handle: NaN, infinity, zero and denormal. It then presents either adder-ready operands or a precomputed special result from a registered output stage that feeds the adder and the FPU writeback mux.

---
 rtl/fpu_addsub_frontend.sv | 166 ++++++++++++++++
 tb/tb_fpu_addsub_frontend.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_frontend.sv
// Operand front-end for the single-precision add/subtract unit.
// Operand pairs are buffered in a small circular FIFO. The head entry is
// classified, and IEEE-754 special cases (NaN, Inf, zero/denormal) are
// resolved into a precomputed result. The output register feeds both the
// adder and the writeback mux.
module fpu_addsub_frontend #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic                       in_op,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_n1,
  output logic [31:0]                out_n2,
  output logic                       out_sel,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_special,
  output logic [31:0]                out_special_result,
  output logic                       out_nv,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0]      mem_a   [DEPTH];
  logic [31:0]      mem_b   [DEPTH];
  logic             mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic push;
  logic pop;

  // in_ready looks only at the registered count, never at out_ready
  assign in_ready  = (count < CW'(DEPTH));
  assign occupancy = count;
  assign push      = !flush && in_valid && in_ready;
  assign pop       = !flush && (count != '0) && (!out_valid || out_ready);

  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic             head_op;
  logic [TAG_W-1:0] head_tag;

  assign head_a   = mem_a[rd_ptr];
  assign head_b   = mem_b[rd_ptr];
  assign head_op  = mem_op[rd_ptr];
  assign head_tag = mem_tag[rd_ptr];

  // FIFO storage write; contents need no reset since count guards reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_op[wr_ptr]  <= in_op;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  // Pointer and count bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic eb;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic        spec;
  logic [31:0] spec_res;
  logic        spec_nv;

  assign eb     = head_b[31] ^ head_op;
  assign a_nan  = (head_a[30:23] == 8'hFF) && (head_a[22:0] != '0);
  assign b_nan  = (head_b[30:23] == 8'hFF) && (head_b[22:0] != '0);
  assign a_snan = a_nan && !head_a[22];
  assign b_snan = b_nan && !head_b[22];
  assign a_inf  = (head_a[30:23] == 8'hFF) && (head_a[22:0] == '0);
  assign b_inf  = (head_b[30:23] == 8'hFF) && (head_b[22:0] == '0);
  // exponent zero covers denormals, which are flushed to zero
  assign a_zero = (head_a[30:23] == 8'h00);
  assign b_zero = (head_b[30:23] == 8'h00);

  // Special-case resolution in priority order on the head entry
  always_comb begin
    spec     = 1'b1;
    spec_res = '0;
    spec_nv  = 1'b0;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
      spec_nv  = a_snan || b_snan;
    end else if (a_inf && b_inf && (head_a[31] != eb)) begin
      spec_res = QNAN;
      spec_nv  = 1'b1;
    end else if (a_inf) begin
      spec_res = head_a;
    end else if (b_inf) begin
      spec_res = {eb, 8'hFF, 23'h0};
    end else if (a_zero && b_zero) begin
      spec_res = {head_a[31] & eb, 31'h0};
    end else if (a_zero) begin
      spec_res = {eb, head_b[30:0]};
    end else if (b_zero) begin
      spec_res = head_a;
    end else begin
      spec = 1'b0;
    end
  end

  // Output register: load on pop, hold under stall, drop valid when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid          <= 1'b0;
      out_n1             <= '0;
      out_n2             <= '0;
      out_sel            <= 1'b0;
      out_tag            <= '0;
      out_special        <= 1'b0;
      out_special_result <= '0;
      out_nv             <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_special <= 1'b0;
      out_nv      <= 1'b0;
    end else if (pop) begin
      out_valid          <= 1'b1;
      out_n1             <= head_a;
      out_n2             <= head_b;
      out_sel            <= head_op;
      out_tag            <= head_tag;
      out_special        <= spec;
      out_special_result <= spec_res;
      out_nv             <= spec_nv;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_frontend.sv
// Self-checking bench for fpu_addsub_frontend: directed special cases,
// backpressure, flush, mid-stream reset, then randomized traffic against
// a queue-based reference model.
module tb_fpu_addsub_frontend;

  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_n1;
  logic [31:0]      out_n2;
  logic             out_sel;
  logic [TAG_W-1:0] out_tag;
  logic             out_special;
  logic [31:0]      out_special_result;
  logic             out_nv;
  logic [$clog2(DEPTH):0] occupancy;

  fpu_addsub_frontend #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_n1(out_n1), .out_n2(out_n2), .out_sel(out_sel), .out_tag(out_tag),
    .out_special(out_special), .out_special_result(out_special_result),
    .out_nv(out_nv), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             op;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t q[$];
  op_t z;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  accepted = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // operand kind: 0 finite nonzero, 1 zero/denormal, 2 inf, 3 qNaN, 4 sNaN
  function automatic int kind(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 1;
    if (x[30:23] != 8'hFF) return 0;
    if (x[22:0] == 23'h0) return 2;
    return x[22] ? 3 : 4;
  endfunction

  function automatic void model(input op_t t, output logic sp, output logic [31:0] res,
                                output logic nv);
    int   ka;
    int   kb;
    logic sa;
    logic sb;
    ka = kind(t.a);
    kb = kind(t.b);
    sa = t.a[31];
    sb = t.b[31] ^ t.op;
    sp = 1'b1;
    nv = 1'b0;
    res = 32'h0;
    if (ka >= 3 || kb >= 3) begin
      res = 32'h7FC0_0000;
      nv  = (ka == 4) || (kb == 4);
    end else if (ka == 2 && kb == 2 && sa != sb) begin
      res = 32'h7FC0_0000;
      nv  = 1'b1;
    end else if (ka == 2) res = t.a;
    else if (kb == 2)     res = {sb, 8'hFF, 23'h0};
    else if (ka == 1 && kb == 1) res = {sa & sb, 31'h0};
    else if (ka == 1)     res = {sb, t.b[30:0]};
    else if (kb == 1)     res = t.a;
    else                  sp = 1'b0;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 7))
      0: return {s, 31'h0};
      1: return {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
      2: return {s, 8'hFF, 23'h0};
      3: return {s, 8'hFF, 1'b1, 22'($urandom)};
      4: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 22'h3FFFFF))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  task automatic consume();
    op_t         e;
    logic        sp;
    logic        nv;
    logic [31:0] r;
    if (q.size() == 0) begin
      chk("spurious_out_valid", 32'(out_valid), 32'd0);
      return;
    end
    e = q.pop_front();
    model(e, sp, r, nv);
    chk("sb_tag", 32'(out_tag), 32'(e.tag));
    chk("sb_n1", out_n1, e.a);
    chk("sb_n2", out_n2, e.b);
    chk("sb_sel", 32'(out_sel), 32'(e.op));
    chk("sb_special", 32'(out_special), 32'(sp));
    if (sp) chk("sb_result", out_special_result, r);
    chk("sb_nv", 32'(out_nv), 32'(nv));
  endtask

  // one clock cycle, entered and left at a falling edge
  task automatic cycle(input logic v, input op_t t, input logic ordy, input logic fl);
    in_valid  = v;
    in_a      = t.a;
    in_b      = t.b;
    in_op     = t.op;
    in_tag    = t.tag;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (fl) q.delete();
    else begin
      if (out_valid && out_ready) consume();
      if (in_valid && in_ready) begin
        q.push_back(t);
        accepted++;
      end
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic esp, input logic [31:0] eres,
                          input logic env);
    op_t t;
    t.a = a;
    t.b = b;
    t.op = op;
    t.tag = TAG_W'($urandom);
    cycle(1'b1, t, 1'b0, 1'b0);
    chk({name, "_valid_after_1"}, 32'(out_valid), 32'd0);
    chk({name, "_occ_after_1"}, 32'(occupancy), 32'd1);
    cycle(1'b0, z, 1'b0, 1'b0);
    chk({name, "_valid_after_2"}, 32'(out_valid), 32'd1);
    chk({name, "_n1"}, out_n1, a);
    chk({name, "_n2"}, out_n2, b);
    chk({name, "_sel"}, 32'(out_sel), 32'(op));
    chk({name, "_special"}, 32'(out_special), 32'(esp));
    if (esp) chk({name, "_result"}, out_special_result, eres);
    chk({name, "_nv"}, 32'(out_nv), 32'(env));
    cycle(1'b0, z, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    op_t t;
    int  guard;
    z = '{a: 32'h0, b: 32'h0, op: 1'b0, tag: '0};
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = 1'b0;
    in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_n1", out_n1, 32'd0);
    chk("rst_result", out_special_result, 32'd0);
    chk("rst_nv", 32'(out_nv), 32'd0);

    directed("add_normal", 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    directed("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b1, 32'h7FC0_0000, 1'b1);
    directed("zero_a", 32'h0000_0000, 32'h4040_0000, 1'b1, 1'b1, 32'hC040_0000, 1'b0);
    directed("denorm_a", 32'h0000_0001, 32'h4040_0000, 1'b1, 1'b1, 32'hC040_0000, 1'b0);
    directed("snan_a", 32'h7F80_0001, 32'h3F80_0000, 1'b0, 1'b1, 32'h7FC0_0000, 1'b1);
    directed("qnan_a", 32'h7FC0_0001, 32'h3F80_0000, 1'b0, 1'b1, 32'h7FC0_0000, 1'b0);

    // backpressure: 5 offers under stall, only DEPTH+1 fit
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      t.a = 32'h3F80_0000 + 32'(i);
      t.b = 32'h4000_0000;
      t.op = 1'(i);
      t.tag = TAG_W'(i + 3);
      cycle(1'b1, t, 1'b0, 1'b0);
    end
    chk("bp_accepted", 32'(accepted), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_occupancy", 32'(occupancy), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("bp_drain_valid", 32'(out_valid), 32'd1);
      cycle(1'b0, z, 1'b1, 1'b0);
    end
    chk("bp_drained_valid", 32'(out_valid), 32'd0);
    chk("bp_drained_in_ready", 32'(in_ready), 32'd1);
    chk("bp_drained_queue", 32'(q.size()), 32'd0);

    // flush with three ops held
    accepted = 0;
    for (int i = 0; i < 3; i++) begin
      t.a = 32'h4100_0000 + 32'(i);
      t.b = 32'h3F00_0000;
      t.op = 1'b0;
      t.tag = TAG_W'(i + 10);
      cycle(1'b1, t, 1'b0, 1'b0);
    end
    chk("fl_accepted", 32'(accepted), 32'd3);
    chk("fl_pre_occupancy", 32'(occupancy), 32'd2);
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    cycle(1'b0, z, 1'b0, 1'b1);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_occupancy", 32'(occupancy), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    t.tag = TAG_W'(20);
    cycle(1'b1, t, 1'b1, 1'b1);
    chk("fl_over_push_occupancy", 32'(occupancy), 32'd0);
    chk("fl_over_push_valid", 32'(out_valid), 32'd0);

    // asynchronous reset in the middle of a stream
    for (int i = 0; i < 2; i++) begin
      t.a = 32'h4200_0000 + 32'(i);
      t.tag = TAG_W'(i + 24);
      cycle(1'b1, t, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_n1", out_n1, 32'd0);
    chk("arst_tag", 32'(out_tag), 32'd0);
    chk("arst_result", out_special_result, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle(1'b0, z, 1'b1, 1'b0);
    chk("arst_no_stale", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      t.a = rand_operand();
      t.b = rand_operand();
      t.op = 1'($urandom);
      t.tag = TAG_W'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), t, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 63) == 0));
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      cycle(1'b0, z, 1'b1, 1'b0);
      guard++;
    end
    chk("rand_drain_empty", 32'(q.size()), 32'd0);
    cycle(1'b0, z, 1'b1, 1'b0);
    chk("rand_final_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
